// File: rtl/uart_dbg_tx_if.sv
// uart_dbg_tx_if: producer-side bundle for the debug UART transmitter.
//   wr   : write strobe, enqueue msg this cycle
//   msg  : byte to enqueue
//   full : queue holds its full depth of bytes
//   tx   : serial line output, idles high
// master = debug producer / board side, slave = uart_dbg_tx.
interface uart_dbg_tx_if;
    logic       wr;
    logic [7:0] msg;
    logic       full;
    logic       tx;

    modport master (output wr, output msg, input full, input tx);
    modport slave  (input wr, input msg, output full, output tx);
endinterface

// File: rtl/uart_dbg_tx.sv
// uart_dbg_tx: byte queue feeding an 8N1 serializer for debug messages.
// Ports:
//   clk   : system clock, all logic on its rising edge
//   reset : synchronous active-high reset, abandons any frame in flight
//   bus   : uart_dbg_tx_if.slave (wr/msg in, full/tx out)
// Parameters:
//   SYS_CLK_FREQ   : system clock in Hz
//   BAUD_RATE      : line bit rate
//   MSG_QUEUE_SIZE : queue depth in bytes, power of two, >= 2
module uart_dbg_tx #(
    parameter int SYS_CLK_FREQ   = 12000000,
    parameter int BAUD_RATE      = 115200,
    parameter int MSG_QUEUE_SIZE = 16
) (
    input  logic         clk,
    input  logic         reset,
    uart_dbg_tx_if.slave bus
);

    // A clock slower than the baud rate still gets one cycle per bit.
    localparam int CPB_RAW      = SYS_CLK_FREQ / BAUD_RATE;
    localparam int CLKS_PER_BIT = (CPB_RAW < 1) ? 1 : CPB_RAW;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W        = $clog2(MSG_QUEUE_SIZE);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W:0]   DEPTH    = (PTR_W + 1)'(MSG_QUEUE_SIZE);
    localparam logic [PTR_W:0]   CNT_INC  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_INC  = PTR_W'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    logic [7:0]       mem_q [MSG_QUEUE_SIZE];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [PTR_W:0]   count_q, count_d;

    state_e           state_q;
    logic [CNT_W-1:0] clk_cnt_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             tx_q;

    logic queue_full, queue_empty, push, pop, bit_done;

    // full/empty decode the registered count, so a push into a full queue is
    // dropped even when a pop frees a slot on the same edge.
    assign queue_full  = (count_q == DEPTH);
    assign queue_empty = (count_q == '0);
    assign push        = bus.wr && !queue_full;
    assign bit_done    = (clk_cnt_q == CNT_LAST);
    // Pop from idle, or at the last cycle of a stop bit so frames run back to back.
    assign pop         = !queue_empty &&
                         ((state_q == IDLE) || ((state_q == STOP) && bit_done));

    assign bus.full = queue_full;
    assign bus.tx   = tx_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_INC;
        end else if (!push && pop) begin
            count_d = count_q - CNT_INC;
        end
    end

    // Queue control
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PTR_INC;
            if (pop)  rptr_q <= rptr_q + PTR_INC;
            count_q <= count_d;
        end
    end

    // Queue storage
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= bus.msg;
    end

    // Shift register: loaded on pop, shifted at the end of each data bit
    always_ff @(posedge clk) begin
        if (pop) begin
            shift_q <= mem_q[rptr_q];
        end else if ((state_q == DATA) && bit_done) begin
            shift_q <= shift_q >> 1;
        end
    end

    // Transmit FSM with registered tx
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            tx_q      <= 1'b1;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q      <= 1'b1;
                    clk_cnt_q <= '0;
                    if (pop) begin
                        state_q   <= START;
                        tx_q      <= 1'b0;
                        bit_cnt_q <= '0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        clk_cnt_q <= '0;
                        state_q   <= DATA;
                        tx_q      <= shift_q[0];
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_ONE;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        clk_cnt_q <= '0;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            // shift_q[1] is the bit that lands in [0] on this edge
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_ONE;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        clk_cnt_q <= '0;
                        if (pop) begin
                            state_q   <= START;
                            tx_q      <= 1'b0;
                            bit_cnt_q <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_dbg_tx.sv
// tb_uart_dbg_tx: three transmitter instances exercised from one bench.
//   dut_a: 4 clocks/bit, depth 16 (frame table, mid-frame reset)
//   dut_b: 4 clocks/bit, depth 8  (fill/overflow, loopback, random traffic)
//   dut_c: clamped to 1 clock/bit, depth 8 (frame table)
module tb_uart_dbg_tx;

    localparam int CPB_A   = 4;
    localparam int CPB_B   = 4;
    localparam int CPB_C   = 1;
    localparam int DEPTH_B = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;

    uart_dbg_tx_if ifa ();
    uart_dbg_tx_if ifb ();
    uart_dbg_tx_if ifc ();

    uart_dbg_tx #(.SYS_CLK_FREQ(16), .BAUD_RATE(4), .MSG_QUEUE_SIZE(16)) dut_a (
        .clk(clk), .reset(rst_a), .bus(ifa));
    uart_dbg_tx #(.SYS_CLK_FREQ(16), .BAUD_RATE(4), .MSG_QUEUE_SIZE(8)) dut_b (
        .clk(clk), .reset(rst_b), .bus(ifb));
    uart_dbg_tx #(.SYS_CLK_FREQ(1), .BAUD_RATE(4), .MSG_QUEUE_SIZE(8)) dut_c (
        .clk(clk), .reset(rst_c), .bus(ifc));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int d, input logic w, input logic [7:0] m);
        case (d)
            0: begin ifa.wr = w; ifa.msg = m; end
            1: begin ifb.wr = w; ifb.msg = m; end
            default: begin ifc.wr = w; ifc.msg = m; end
        endcase
    endtask

    function automatic logic get_tx(input int d);
        case (d)
            0: return ifa.tx;
            1: return ifb.tx;
            default: return ifc.tx;
        endcase
    endfunction

    function automatic logic get_full(input int d);
        case (d)
            0: return ifa.full;
            1: return ifb.full;
            default: return ifc.full;
        endcase
    endfunction

    // ---------------- frame-level reference model for dut_b ----------------
    // The transmitter may take a byte whenever it is not busy with a frame; a
    // frame starting at edge P occupies the line until edge P + 10*CPB.
    logic [7:0] mq[$];      // bytes waiting in the queue
    logic [7:0] exp_q[$];   // bytes expected on the line, in order
    int         exp_t[$];   // cycle at which each expected frame starts
    int         next_free = 0;

    task automatic step_b(input logic w, input logic [7:0] m);
        int  e;
        bit  mfull;
        bit  do_pop;
        ifb.wr = w;
        ifb.msg = m;
        e      = cyc + 1;
        mfull  = (mq.size() == DEPTH_B);
        do_pop = (mq.size() > 0) && (e >= next_free);
        if (do_pop) begin
            exp_q.push_back(mq.pop_front());
            exp_t.push_back(e);
            next_free = e + 10 * CPB_B;
        end
        if (w && !mfull) mq.push_back(m);
        tick();
        check("full_b", ifb.full, (mq.size() == DEPTH_B));
    endtask

    task automatic drain_b(input string tag);
        int n = 0;
        while ((mq.size() != 0 || cyc < next_free + 10 * CPB_B) && n < 3000) begin
            step_b(1'b0, 8'h00);
            n++;
        end
        check({tag, "_drain_bounded"}, (n < 3000), 1);
        check({tag, "_frames_outstanding"}, exp_q.size(), 0);
    endtask

    // ---------------- 8N1 receiver on dut_b's line ----------------
    logic [7:0] rx_log[$];
    int         rx_t[$];

    initial begin
        bit         active = 0;
        int         n = 0;
        int         start = 0;
        int         j;
        logic [7:0] rbyte = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_b === 1'b1) begin
                active = 0;
            end else if (!active) begin
                if (ifb.tx === 1'b0) begin
                    active = 1;
                    n = 0;
                    start = cyc;
                end
            end else begin
                n++;
            end
            if (active && (n % CPB_B == CPB_B / 2)) begin
                j = n / CPB_B;
                if (j == 0) begin
                    check("rx_start_bit", ifb.tx, 0);
                end else if (j <= 8) begin
                    rbyte[j-1] = ifb.tx;
                end else begin
                    check("rx_stop_bit", ifb.tx, 1);
                    active = 0;
                    rx_log.push_back(rbyte);
                    rx_t.push_back(start);
                    check("rx_frame_expected", (exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        check("rx_byte", rbyte, exp_q.pop_front());
                        check("rx_start_cycle", start, exp_t.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- directed frame checks ----------------
    typedef struct {
        int         dut;
        logic [7:0] data;
        logic [9:0] frame;   // bit 0 is sent first (start), bit 9 last (stop)
    } vec_t;

    vec_t vecs[6];

    task automatic send_frame(input int d, input logic [7:0] data, input logic [9:0] frame,
                              input string tag);
        int cpb = (d == 2) ? CPB_C : CPB_A;
        set_in(d, 1'b1, data);
        tick();
        set_in(d, 1'b0, 8'h00);
        check({tag, "_tx_high_at_write"}, get_tx(d), 1);
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < cpb; c++) begin
                tick();
                check($sformatf("%s_bit%0d_clk%0d", tag, i, c), get_tx(d), frame[i]);
            end
        end
        tick();
        check({tag, "_idle_after"}, get_tx(d), 1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int low_cnt;
        logic [7:0] dlt;

        vecs[0] = '{0, 8'hA5, 10'b1101001010};
        vecs[1] = '{0, 8'h00, 10'b1000000000};
        vecs[2] = '{0, 8'hFF, 10'b1111111110};
        vecs[3] = '{2, 8'h3C, 10'b1001111000};
        vecs[4] = '{2, 8'hC3, 10'b1110000110};
        vecs[5] = '{2, 8'h81, 10'b1100000010};

        set_in(0, 1'b0, 8'h00);
        set_in(1, 1'b0, 8'h00);
        set_in(2, 1'b0, 8'h00);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        tick();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // Reset state and quiet idle line
        for (int k = 0; k < 20; k++) begin
            for (int d = 0; d < 3; d++) begin
                check($sformatf("reset_tx_d%0d", d), get_tx(d), 1);
                check($sformatf("reset_full_d%0d", d), get_full(d), 0);
            end
            tick();
        end

        // Frame table
        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].dut, vecs[v].data, vecs[v].frame, $sformatf("vec%0d", v));
        end

        // Mid-frame reset on dut_a: 0x55 in flight, 0x11 and 0x22 queued
        set_in(0, 1'b1, 8'h55); tick();
        set_in(0, 1'b1, 8'h11); tick();
        set_in(0, 1'b1, 8'h22); tick();
        set_in(0, 1'b0, 8'h00);
        for (int k = 0; k < 7; k++) tick();
        check("midrst_in_data_bit1", ifa.tx, 0);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        check("midrst_tx", ifa.tx, 1);
        check("midrst_full", ifa.full, 0);
        low_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (ifa.tx !== 1'b1) low_cnt++;
        end
        check("midrst_queue_empty", low_cnt, 0);
        send_frame(0, 8'h81, 10'b1100000010, "post_rst");

        // Fill and overflow on dut_b
        rx_log.delete();
        rx_t.delete();
        for (int k = 1; k <= 12; k++) begin
            step_b(1'b1, 8'(k - 1));
            check($sformatf("fill_full_after_write%0d", k), ifb.full, (k >= 9));
        end
        drain_b("fill");
        check("fill_rx_count", rx_log.size(), 9);
        for (int i = 0; i < rx_log.size() && i < 9; i++)
            check($sformatf("fill_rx%0d", i), rx_log[i], i);
        for (int i = 1; i < rx_t.size(); i++)
            check($sformatf("fill_contig%0d", i), rx_t[i] - rx_t[i-1], 40);

        // Loopback: incrementing byte every cycle for 1000 cycles
        rx_log.delete();
        rx_t.delete();
        for (int i = 0; i < 1000; i++) step_b(1'b1, i[7:0]);
        drain_b("loop");
        check("loop_rx_at_least_8", (rx_log.size() >= 8), 1);
        for (int i = 0; i < 8 && i < rx_log.size(); i++)
            check($sformatf("loop_first%0d", i), rx_log[i], i);
        for (int i = 1; i < rx_log.size(); i++) begin
            dlt = rx_log[i] - rx_log[i-1];
            check($sformatf("loop_increasing%0d", i), (dlt >= 8'd1 && dlt <= 8'd127), 1);
        end

        // Randomized bursts with varying write density
        for (int b = 0; b < 15; b++) begin
            int pct = $urandom_range(5, 80);
            for (int i = 0; i < 200; i++)
                step_b(($urandom_range(0, 99) < pct), 8'($urandom));
        end
        drain_b("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
